voice_lut_scheduler: RTL and testbench

//  Time-multiplexes one shared phase-to-sample wave lookup (7-bit phase and
//  7-bit program in, 8-bit unsigned sample out, fixed pipeline latency, gated
//  by its ce) across VOICES oscillator voices.
//  On each sample-rate tick it snapshots all voice phases and programs, issues
//  one lookup per voice on consecutive clocks, and drains the lookup pipeline.
//  It sums the returned samples of the enabled voices into one signed mix

---
 rtl/voice_lut_scheduler.sv | 111 +++++++++++
 tb/tb_voice_lut_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_lut_scheduler.sv
// voice_lut_scheduler: shares one pipelined phase-to-sample lookup across VOICES
// voices on every sample tick and sums the enabled voices' centred samples.
module voice_lut_scheduler #(
    parameter int VOICES = 4,
    parameter int LAT    = 2,
    localparam int AW    = 8 + $clog2(VOICES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [7*VOICES-1:0] voice_phase,
    input  logic [7*VOICES-1:0] voice_prog,
    input  logic [VOICES-1:0]   voice_en,
    output logic                lut_ce,
    output logic [6:0]          lut_phase,
    output logic [6:0]          lut_prog,
    input  logic [7:0]          lut_sample,
    output logic [AW-1:0]       mix_out,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun
);
    localparam int SW = $clog2(VOICES);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [SW-1:0] LAST_SLOT  = SW'(VOICES - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [7*VOICES-1:0]  snap_phase, snap_prog;
    logic [VOICES-1:0]    snap_en;
    logic [SW-1:0]        slot;
    logic [DW-1:0]        drain_cnt;
    logic [LAT-1:0]       vpipe;
    logic signed [AW-1:0] acc, acc_next;
    logic signed [8:0]    delta;
    logic                 start, push;

    // The valid pipe mirrors the lookup latency so each tap lines up with its sample.
    assign push     = (state == ISSUE) ? snap_en[slot] : 1'b0;
    assign delta    = $signed({1'b0, lut_sample}) - 9'sd128;
    assign acc_next = (lut_ce && vpipe[LAT-1]) ? acc + AW'(delta) : acc;
    assign busy     = (state != IDLE);
    assign overrun  = tick && busy;

    always_comb begin
        state_next = state;
        lut_ce     = 1'b0;
        lut_phase  = 7'd0;
        lut_prog   = 7'd0;
        mix_valid  = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                lut_ce    = 1'b1;
                lut_phase = snap_phase[7*int'(slot) +: 7];
                lut_prog  = snap_prog[7*int'(slot) +: 7];
                if (slot == LAST_SLOT) state_next = DRAIN;
            end
            DRAIN: begin
                lut_ce = 1'b1;
                if (drain_cnt == LAST_DRAIN) state_next = DONE;
            end
            DONE: begin
                mix_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // mix_out is loaded on the last drain clock so it is already valid while mix_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap_phase <= '0;
            snap_prog  <= '0;
            snap_en    <= '0;
            slot       <= '0;
            drain_cnt  <= '0;
            vpipe      <= '0;
            acc        <= '0;
            mix_out    <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                snap_phase <= voice_phase;
                snap_prog  <= voice_prog;
                snap_en    <= voice_en;
                slot       <= '0;
                drain_cnt  <= '0;
                acc        <= '0;
            end else begin
                if (state == ISSUE && slot != LAST_SLOT) slot <= slot + 1'b1;
                if (state == DRAIN && drain_cnt != LAST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
                if (lut_ce) begin
                    vpipe <= LAT'({vpipe, push});
                    acc   <= acc_next;
                end
                if (state == DRAIN && state_next == DONE) mix_out <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_voice_lut_scheduler.sv
// Self-checking bench for voice_lut_scheduler: directed scans against a
// behavioural 2-stage lookup, expected mixes queued at tick and popped at mix_valid.
module tb_voice_lut_scheduler;
    localparam int VOICES = 4;
    localparam int LAT    = 2;
    localparam int AW     = 8 + $clog2(VOICES);
    localparam int SCAN   = VOICES + LAT + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                tick;
    logic [7*VOICES-1:0] voice_phase, voice_prog;
    logic [VOICES-1:0]   voice_en;
    logic                lut_ce;
    logic [6:0]          lut_phase, lut_prog;
    logic [7:0]          lut_sample;
    logic [AW-1:0]       mix_out;
    logic                mix_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mix_q[$];
    logic [6:0] phase_seen [VOICES];
    logic [6:0] prog_seen  [VOICES];

    // Lookup model: sample is either a constant or the presented phase, 2 ce-gated stages.
    logic       lut_mode  = 1'b0;
    logic [7:0] lut_const = 8'd128;
    logic [7:0] lut_s1    = 8'd0;
    logic [7:0] lut_s2    = 8'd0;

    always @(posedge clk) begin
        if (lut_ce) begin
            lut_s1 <= lut_mode ? {1'b0, lut_phase} : lut_const;
            lut_s2 <= lut_s1;
        end
    end
    assign lut_sample = lut_s2;

    always #5 clk = ~clk;

    voice_lut_scheduler #(.VOICES(VOICES), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .voice_phase (voice_phase),
        .voice_prog  (voice_prog),
        .voice_en    (voice_en),
        .lut_ce      (lut_ce),
        .lut_phase   (lut_phase),
        .lut_prog    (lut_prog),
        .lut_sample  (lut_sample),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    function automatic int expMix(input logic mode, input logic [7:0] c,
                                  input logic [7*VOICES-1:0] ph, input logic [VOICES-1:0] en);
        int s = 0;
        for (int k = 0; k < VOICES; k++)
            if (en[k]) s += (mode ? int'(ph[7*k +: 7]) : int'(c)) - 128;
        return s;
    endfunction

    task automatic applyStimulus(input logic t);
        @(negedge clk);
        tick = t;
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkMix(input string tag);
        int exp;
        if (mix_q.size() > 0) exp = mix_q.pop_front();
        else exp = 32'h7FFF_FFFF;
        checkOutput({tag, "_mix"}, $signed(mix_out), exp);
    endtask

    task automatic startScan(input string tag, input int exp);
        applyStimulus(1'b1);
        mix_q.push_back(exp);
        checkOutput({tag, "_busy_at_tick"}, busy, 0);
        checkOutput({tag, "_ovr_at_tick"}, overrun, 0);
    endtask

    // Walks clocks T+1..T+SCAN after an accepted tick, checking timing each clock.
    task automatic scanCycles(input string tag, input int ovr_at, input int chg_at);
        int pulses = 0;
        for (int k = 1; k <= SCAN; k++) begin
            applyStimulus(k == ovr_at);
            if (k == chg_at) voice_phase = ~voice_phase;
            checkOutput($sformatf("%s_ce%0d", tag, k), lut_ce, (k <= VOICES + LAT));
            checkOutput($sformatf("%s_busy%0d", tag, k), busy, 1);
            checkOutput($sformatf("%s_ovr%0d", tag, k), overrun, (k == ovr_at));
            if (k <= VOICES) begin
                phase_seen[k-1] = lut_phase;
                prog_seen[k-1]  = lut_prog;
            end
            if (k == SCAN) checkOutput({tag, "_phase_done"}, lut_phase, 0);
            if (mix_valid) begin
                pulses++;
                checkOutput({tag, "_latency"}, k, SCAN);
                checkMix(tag);
            end
        end
        checkOutput({tag, "_pulses"}, pulses, 1);
    endtask

    task automatic checkIdle(input string tag);
        applyStimulus(1'b0);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_ce"}, lut_ce, 0);
        checkOutput({tag, "_idle_valid"}, mix_valid, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ce"}, lut_ce, 0);
        checkOutput({tag, "_phase"}, lut_phase, 0);
        checkOutput({tag, "_prog"}, lut_prog, 0);
        checkOutput({tag, "_mix"}, $signed(mix_out), 0);
        checkOutput({tag, "_valid"}, mix_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int pulses;
        int exp;
        rst_n       = 1'b0;
        tick        = 1'b0;
        voice_phase = '0;
        voice_prog  = '0;
        voice_en    = '1;

        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkResetOutputs("rst");
        applyStimulus(1'b0);
        rst_n = 1'b1;
        checkIdle("post_rst");

        $display("[TB] scan with constant 200, all voices enabled");
        lut_mode  = 1'b0;
        lut_const = 8'd200;
        startScan("t1", 288);
        scanCycles("t1", 0, 0);
        checkIdle("t1");

        $display("[TB] scan with sample = phase");
        lut_mode    = 1'b1;
        voice_phase = {7'd64, 7'd127, 7'd10, 7'd0};
        voice_prog  = {7'd8, 7'd7, 7'd6, 7'd5};
        voice_en    = 4'b1111;
        startScan("t2", -311);
        scanCycles("t2", 0, 0);
        for (int i = 0; i < VOICES; i++) begin
            checkOutput($sformatf("t2_phase_order%0d", i), phase_seen[i], voice_phase[7*i +: 7]);
            checkOutput($sformatf("t2_prog_order%0d", i), prog_seen[i], voice_prog[7*i +: 7]);
        end

        $display("[TB] extreme samples and all voices disabled");
        lut_mode  = 1'b0;
        lut_const = 8'd255;
        startScan("t3a", 508);
        scanCycles("t3a", 0, 0);
        lut_const = 8'd0;
        startScan("t3b", -512);
        scanCycles("t3b", 0, 0);
        lut_const = 8'd200;
        voice_en  = 4'b0000;
        startScan("t3c", 0);
        scanCycles("t3c", 0, 0);

        $display("[TB] overrun during issue and snapshot isolation");
        lut_mode    = 1'b1;
        voice_en    = 4'b1111;
        voice_phase = {7'd50, 7'd40, 7'd30, 7'd20};
        exp = expMix(1'b1, 8'd0, voice_phase, voice_en);
        startScan("t4", exp);
        scanCycles("t4", 3, 2);
        checkIdle("t4");

        $display("[TB] reset in the middle of a scan");
        lut_mode  = 1'b0;
        lut_const = 8'd100;
        voice_en  = 4'b1010;
        applyStimulus(1'b1);
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0);
        checkOutput("t5_busy_before_rst", busy, 1);
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("t5_async");
        pulses = 0;
        for (int k = 0; k < SCAN + 2; k++) begin
            applyStimulus(1'b0);
            if (mix_valid) pulses++;
        end
        checkOutput("t5_no_valid", pulses, 0);
        rst_n = 1'b1;
        checkIdle("t5_release");
        exp = expMix(1'b0, lut_const, voice_phase, voice_en);
        startScan("t5", exp);
        scanCycles("t5", 0, 0);

        $display("[TB] back-to-back ticks");
        voice_en  = 4'b1111;
        lut_const = 8'd150;
        startScan("t6a", 88);
        scanCycles("t6a", 0, 0);
        lut_const = 8'd180;
        startScan("t6b", 208);
        scanCycles("t6b", SCAN, 0);
        checkIdle("t6");

        checkOutput("queue_empty", mix_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
